// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: per-channel duty adjusted by debounced buttons,
// edge/center-aligned counting, optional phase stagger, period-boundary double buffering.
module pwm_lane #(
  parameter int WIDTH     = 8,
  parameter int PERIOD    = 10,
  parameter int DUTY_INIT = 5,
  parameter int OFF       = 0
) (
  input  logic             clk_out,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             wrap,
  input  logic             mode_active,
  input  logic             stag_active,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm,
  output logic [WIDTH-1:0] shadow
);
  localparam logic [WIDTH-1:0] P_W   = WIDTH'(PERIOD);
  localparam logic [WIDTH:0]   P_X   = (WIDTH+1)'(PERIOD);
  localparam logic [WIDTH:0]   OFF_X = (WIDTH+1)'(OFF);

  logic [WIDTH-1:0] active;
  logic [WIDTH:0]   sum, v;

  // cnt + OFF < 2*PERIOD, so one conditional subtract is the modulo
  always_comb begin
    sum = {1'b0, cnt} + OFF_X;
    v   = {1'b0, cnt};
    if (stag_active && !mode_active)
      v = (sum >= P_X) ? sum - P_X : sum;
  end

  always_ff @(posedge clk_out or posedge rst_n) begin
    if (rst_n) begin
      shadow <= WIDTH'(DUTY_INIT);
      active <= WIDTH'(DUTY_INIT);
      pwm    <= 1'b0;
    end else begin
      if (inc && shadow < P_W)           shadow <= shadow + 1'b1;
      else if (dec && shadow != '0)      shadow <= shadow - 1'b1;
      if (wrap)                          active <= shadow;
      pwm <= (v < {1'b0, active});
    end
  end
endmodule

module pwm_multi_gen #(
  parameter int CHANNELS  = 8,
  parameter int WIDTH     = 8,
  parameter int PERIOD    = 10,
  parameter int DUTY_INIT = 5,
  parameter int DEBOUNCE  = 2,
  parameter int SEL_W     = 3
) (
  input  logic                clk_out,
  input  logic                rst_n,
  input  logic                increase_duty,
  input  logic                decrease_duty,
  input  logic [SEL_W-1:0]    ch_sel,
  input  logic                center_mode,
  input  logic                stagger_en,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [WIDTH-1:0]    duty_sel,
  output logic                period_wrap
);
  localparam int              TW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [TW-1:0]   TMAX = TW'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] PM1 = WIDTH'(PERIOD - 1);

  logic [TW-1:0]    tcnt;
  logic             tick;
  logic [1:0]       s1, s2, ev;
  logic             inc_ev, dec_ev;
  logic [WIDTH-1:0] cnt;
  logic             dir, mode_active, stag_active, wrap;
  logic [CHANNELS-1:0]            sel_hit;
  logic [CHANNELS-1:0][WIDTH-1:0] shadow;

  assign tick = (tcnt == TMAX);

  // bit 0 = increase, bit 1 = decrease; both sampled only on ticks
  always_ff @(posedge clk_out or posedge rst_n) begin
    if (rst_n) begin
      tcnt <= '0;
      s1   <= '0;
      s2   <= '0;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      if (tick) begin
        s1 <= {decrease_duty, increase_duty};
        s2 <= s1;
      end
    end
  end

  assign ev     = s1 & ~s2 & {2{tick}};
  assign inc_ev = ev[0];
  assign dec_ev = ev[1] & ~ev[0];

  assign wrap = mode_active ? (dir && cnt == '0) : (cnt == PM1);

  always_ff @(posedge clk_out or posedge rst_n) begin
    if (rst_n) begin
      cnt         <= '0;
      dir         <= 1'b0;
      mode_active <= 1'b0;
      stag_active <= 1'b0;
      period_wrap <= 1'b0;
    end else begin
      period_wrap <= wrap;
      if (wrap) begin
        cnt         <= '0;
        dir         <= 1'b0;
        mode_active <= center_mode;
        stag_active <= stagger_en;
      end else if (!mode_active) begin
        cnt <= cnt + 1'b1;
      end else if (!dir) begin
        // turning point: PERIOD-1 is held for a second cycle on the way down
        if (cnt == PM1) dir <= 1'b1;
        else            cnt <= cnt + 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_lane
      assign sel_hit[i] = (32'(ch_sel) == i);
      pwm_lane #(
        .WIDTH(WIDTH), .PERIOD(PERIOD), .DUTY_INIT(DUTY_INIT),
        .OFF((i * PERIOD) / CHANNELS)
      ) u_lane (
        .clk_out     (clk_out),
        .rst_n       (rst_n),
        .inc         (inc_ev & sel_hit[i]),
        .dec         (dec_ev & sel_hit[i]),
        .wrap        (wrap),
        .mode_active (mode_active),
        .stag_active (stag_active),
        .cnt         (cnt),
        .pwm         (pwm_out[i]),
        .shadow      (shadow[i])
      );
    end
  endgenerate

  always_comb begin
    duty_sel = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (sel_hit[k]) duty_sel = shadow[k];
  end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen: duty buttons, saturation, modes, stagger, reset.
module tb_pwm_multi_gen;
  localparam int CH = 8;
  localparam int W  = 8;

  logic          clk_out = 1'b0;
  logic          rst_n = 1'b1;
  logic          increase_duty = 1'b0, decrease_duty = 1'b0;
  logic [3:0]    ch_sel = '0;
  logic          center_mode = 1'b0, stagger_en = 1'b0;
  logic [CH-1:0] pwm_out;
  logic [W-1:0]  duty_sel;
  logic          period_wrap;

  int n_chk = 0, n_fail = 0;
  int hi [CH];
  logic [19:0] pat [CH];
  logic [19:0] wpat;
  int wraps, n;
  logic [9:0] stag_exp [CH];

  pwm_multi_gen #(.CHANNELS(CH), .WIDTH(W), .PERIOD(10), .DUTY_INIT(5),
                  .DEBOUNCE(2), .SEL_W(4)) dut (
    .clk_out(clk_out), .rst_n(rst_n), .increase_duty(increase_duty),
    .decrease_duty(decrease_duty), .ch_sel(ch_sel), .center_mode(center_mode),
    .stagger_en(stagger_en), .pwm_out(pwm_out), .duty_sel(duty_sel),
    .period_wrap(period_wrap));

  always #5 clk_out = ~clk_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_out);
    @(negedge clk_out);
  endtask

  task automatic press(input logic inc, input logic dec, input logic [3:0] sel);
    ch_sel = sel;
    increase_duty = inc;
    decrease_duty = dec;
    repeat (12) step();
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    repeat (8) step();
  endtask

  // leaves the bench in the cycle where period_wrap is high (cnt=0)
  task automatic wait_wrap();
    int k;
    k = 0;
    step();
    while (!period_wrap && k < 60) begin
      step();
      k++;
    end
    check("wrap_seen", period_wrap, 1);
  endtask

  task automatic measure(input int len);
    for (int c = 0; c < CH; c++) begin hi[c] = 0; pat[c] = '0; end
    wraps = 0;
    wpat  = '0;
    for (int j = 0; j < len; j++) begin
      step();
      for (int c = 0; c < CH; c++) begin
        pat[c][j] = pwm_out[c];
        hi[c] += int'(pwm_out[c]);
      end
      wpat[j] = period_wrap;
      wraps += int'(period_wrap);
    end
  endtask

  initial begin
    stag_exp[0] = 10'h000; stag_exp[1] = 10'h21F; stag_exp[2] = 10'h30F;
    stag_exp[3] = 10'h383; stag_exp[4] = 10'h3E0; stag_exp[5] = 10'h1F0;
    stag_exp[6] = 10'h0F8; stag_exp[7] = 10'h07C;

    // reset state
    repeat (3) step();
    check("rst_pwm", pwm_out, 0);
    check("rst_wrap", period_wrap, 0);
    check("rst_duty_sel", duty_sel, 5);
    rst_n = 1'b0;

    // defaults: 5/10 on every channel, wraps at 10 and 20
    measure(20);
    for (int c = 0; c < CH; c++)
      check($sformatf("dflt_pat%0d", c), pat[c], 20'h07C1F);
    check("dflt_wpat", wpat, 20'h80200);

    // ch2 single step despite long hold
    press(1'b1, 1'b0, 4'd2);
    check("ch2_duty_sel", duty_sel, 6);
    ch_sel = 4'd0;
    #1 check("ch0_duty_sel", duty_sel, 5);
    wait_wrap();
    measure(10);
    check("ch2_pat", pat[2][9:0], 10'h03F);
    check("ch3_pat", pat[3][9:0], 10'h01F);
    check("ch2_hi", hi[2], 6);

    // saturate high then low on ch0
    repeat (6) press(1'b1, 1'b0, 4'd0);
    check("ch0_sat_hi", duty_sel, 10);
    wait_wrap();
    measure(10);
    check("ch0_const_hi", pat[0][9:0], 10'h3FF);
    repeat (11) press(1'b0, 1'b1, 4'd0);
    check("ch0_sat_lo", duty_sel, 0);
    wait_wrap();
    measure(10);
    check("ch0_const_lo", pat[0][9:0], 10'h000);

    // inc beats dec; invalid select touches nothing
    press(1'b1, 1'b1, 4'd1);
    check("ch1_incwins", duty_sel, 6);
    press(1'b1, 1'b0, 4'd9);
    check("sel9_duty_sel", duty_sel, 0);
    ch_sel = 4'd0; #1 check("sel9_ch0", duty_sel, 0);
    ch_sel = 4'd1; #1 check("sel9_ch1", duty_sel, 6);
    ch_sel = 4'd2; #1 check("sel9_ch2", duty_sel, 6);
    ch_sel = 4'd3; #1 check("sel9_ch3", duty_sel, 5);

    // center mode requested mid-period takes effect at the boundary
    wait_wrap();
    repeat (3) step();
    center_mode = 1'b1;
    n = 0;
    do begin step(); n++; end while (!period_wrap && n < 40);
    check("ctr_switch_dist", n, 7);
    measure(20);
    check("ctr_pat3", pat[3], 20'hF801F);
    check("ctr_pat1", pat[1], 20'hFC03F);
    check("ctr_pat0", pat[0], 20'h00000);
    check("ctr_hi3", hi[3], 10);
    check("ctr_wpat", wpat, 20'h80000);

    // back to edge mode with stagger
    center_mode = 1'b0;
    stagger_en  = 1'b1;
    wait_wrap();
    measure(10);
    for (int c = 0; c < CH; c++)
      check($sformatf("stag_pat%0d", c), pat[c][9:0], stag_exp[c]);
    check("stag_wpat", wpat[9:0], 10'h200);
    stagger_en = 1'b0;

    // reset mid-period discards shadow 8 on ch3
    repeat (3) press(1'b1, 1'b0, 4'd3);
    check("ch3_shadow8", duty_sel, 8);
    wait_wrap();
    repeat (7) step();
    rst_n = 1'b1;
    #1;
    check("mid_rst_pwm", pwm_out, 0);
    check("mid_rst_wrap", period_wrap, 0);
    check("mid_rst_duty", duty_sel, 5);
    repeat (2) step();
    rst_n = 1'b0;
    measure(10);
    for (int c = 0; c < CH; c++)
      check($sformatf("post_rst_pat%0d", c), pat[c][9:0], 10'h01F);
    check("post_rst_wpat", wpat[9:0], 10'h200);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
